// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg: shared state type and sizing constants for pipeline_perf_monitor.
package perf_mon_pkg;

   // Default width of every event counter.
   localparam int unsigned CntWDefault = 32;

   // Width of the consecutive-idle-fetch (drain) counter; covers IDLE_LIMIT up to 255.
   localparam int unsigned DrainW = 8;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: event counter with enable and synchronous clear that sticks at all-ones.
module perf_sat_counter #(
   parameter int unsigned Width = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [Width-1:0] o_cnt
);

   logic [Width-1:0] r_cnt;

   // Count enabled events; clear wins over enable; never wrap past all-ones.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != {Width{1'b1}})) begin
         r_cnt <= r_cnt + Width'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: counts cycles, data-hazard stalls, flushes and retirements of the
// pipelined CPU and flags program completion once the fetch stream stays zero.
// Optional watchdog: define PERF_MON_WATCHDOG_EN to force completion at MAX_CYCLES cycles.
module pipeline_perf_monitor
   import perf_mon_pkg::*;
#(
   parameter int unsigned CNT_W      = CntWDefault,
   parameter int unsigned IDLE_LIMIT = 8,
   parameter int unsigned MAX_CYCLES = 1024
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             clear_i,
   input  logic             stall_i,
   input  logic             branch_i,
   input  logic             flush_i,
   input  logic [31:0]      instr_i,
   input  logic             retire_i,
   output logic [CNT_W-1:0] cycle_o,
   output logic [CNT_W-1:0] stall_o,
   output logic [CNT_W-1:0] flush_o,
   output logic [CNT_W-1:0] retire_o,
   output logic             done_o,
   output logic             timeout_o
);

   localparam logic [DrainW-1:0] LimitCnt = DrainW'(IDLE_LIMIT);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [DrainW-1:0] r_drain;
   logic [DrainW-1:0] w_drain_nxt;
   logic [DrainW-1:0] w_drain_inc;
   logic              w_active;
   logic              w_zero_fetch;
   logic [CNT_W-1:0]  w_cycle;

   // Counting happens only on running edges; a start-low edge is a pause, not a count.
   assign w_active     = !clear_i && start_i && ((r_state == StRun) || (r_state == StDrain));
   assign w_zero_fetch = (instr_i == 32'd0);
   assign w_drain_inc  = r_drain + DrainW'(1);

`ifdef PERF_MON_WATCHDOG_EN
   logic w_wd_hit;
   logic w_tout_set;
   logic r_timeout;

   // Fires on the edge where the cycle count steps onto MAX_CYCLES (wide compare, no truncation).
   assign w_wd_hit = w_active && (w_cycle != {CNT_W{1'b1}}) &&
                     ((65'(w_cycle) + 65'd1) == 65'(MAX_CYCLES));
`endif

   // Next state and drain count; clear overrides every event.
   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain;
`ifdef PERF_MON_WATCHDOG_EN
      w_tout_set  = 1'b0;
`endif
      if (clear_i) begin
         w_state_nxt = StIdle;
         w_drain_nxt = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (start_i) w_state_nxt = StRun;
            end
            StRun: begin
               if (!start_i) begin
                  w_state_nxt = StIdle;
               end else if (w_zero_fetch && !stall_i) begin
                  w_drain_nxt = DrainW'(1);
                  w_state_nxt = (LimitCnt == DrainW'(1)) ? StDone : StDrain;
               end
            end
            StDrain: begin
               if (!start_i) begin
                  w_state_nxt = StIdle;
               end else if (!w_zero_fetch || flush_i) begin
                  w_state_nxt = StRun;
                  w_drain_nxt = '0;
               end else if (!stall_i) begin
                  w_drain_nxt = w_drain_inc;
                  if (w_drain_inc == LimitCnt) w_state_nxt = StDone;
               end
            end
            StDone: begin
               w_state_nxt = StDone;
            end
            default: begin
               w_state_nxt = StIdle;
            end
         endcase
      end
`ifdef PERF_MON_WATCHDOG_EN
      // A natural finish on the same edge takes precedence, so no timeout flag then.
      if (w_wd_hit && (w_state_nxt != StDone)) begin
         w_state_nxt = StDone;
         w_tout_set  = 1'b1;
      end
`endif
   end

   // State and drain-count registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= StIdle;
         r_drain <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_drain <= w_drain_nxt;
      end
   end

`ifdef PERF_MON_WATCHDOG_EN
   // Remember that completion came from the watchdog until reset or clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_timeout <= 1'b0;
      end else if (clear_i) begin
         r_timeout <= 1'b0;
      end else if (w_tout_set) begin
         r_timeout <= 1'b1;
      end
   end

   assign timeout_o = r_timeout;
`else
   logic w_unused_max_cycles;

   assign w_unused_max_cycles = ^MAX_CYCLES;
   assign timeout_o           = 1'b0;
`endif

   assign done_o  = (r_state == StDone);
   assign cycle_o = w_cycle;

   perf_sat_counter #(.Width(CNT_W)) u_cnt_cycle (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_clr (clear_i),
      .i_en  (w_active),
      .o_cnt (w_cycle)
   );

   // Stalls caused by a decoded branch are control, not data, hazards.
   perf_sat_counter #(.Width(CNT_W)) u_cnt_stall (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_clr (clear_i),
      .i_en  (w_active && stall_i && !branch_i),
      .o_cnt (stall_o)
   );

   perf_sat_counter #(.Width(CNT_W)) u_cnt_flush (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_clr (clear_i),
      .i_en  (w_active && flush_i),
      .o_cnt (flush_o)
   );

   perf_sat_counter #(.Width(CNT_W)) u_cnt_retire (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_clr (clear_i),
      .i_en  (w_active && retire_i),
      .o_cnt (retire_o)
   );

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// tb_pipeline_perf_monitor: directed and random stimulus on three differently sized monitors,
// each checked against an event-level reference model.
module tb_pipeline_perf_monitor;

   typedef struct {
      bit              run;
      bit              fin;
      bit              tout;
      int unsigned     zrun;
      longint unsigned cyc;
      longint unsigned stl;
      longint unsigned fls;
      longint unsigned ret;
   } mdl_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        clear;
   logic        stall;
   logic        branch;
   logic        flush;
   logic [31:0] instr;
   logic        retire;

   logic [31:0] cyc_a, stl_a, fls_a, ret_a;
   logic        done_a, tout_a;
   logic [3:0]  cyc_b, stl_b, fls_b, ret_b;
   logic        done_b, tout_b;
   logic [7:0]  cyc_c, stl_c, fls_c, ret_c;
   logic        done_c, tout_c;

   int   n_cmp;
   int   n_bad;
   mdl_t m [3];

   pipeline_perf_monitor #(.CNT_W(32), .IDLE_LIMIT(8), .MAX_CYCLES(1024)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .stall_i(stall),
      .branch_i(branch), .flush_i(flush), .instr_i(instr), .retire_i(retire),
      .cycle_o(cyc_a), .stall_o(stl_a), .flush_o(fls_a), .retire_o(ret_a),
      .done_o(done_a), .timeout_o(tout_a)
   );

   pipeline_perf_monitor #(.CNT_W(4), .IDLE_LIMIT(1), .MAX_CYCLES(1024)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .stall_i(stall),
      .branch_i(branch), .flush_i(flush), .instr_i(instr), .retire_i(retire),
      .cycle_o(cyc_b), .stall_o(stl_b), .flush_o(fls_b), .retire_o(ret_b),
      .done_o(done_b), .timeout_o(tout_b)
   );

   pipeline_perf_monitor #(.CNT_W(8), .IDLE_LIMIT(8), .MAX_CYCLES(20)) u_dut_c (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .stall_i(stall),
      .branch_i(branch), .flush_i(flush), .instr_i(instr), .retire_i(retire),
      .cycle_o(cyc_c), .stall_o(stl_c), .flush_o(fls_c), .retire_o(ret_c),
      .done_o(done_c), .timeout_o(tout_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input longint unsigned got,
                           input longint unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint unsigned sat_inc(input longint unsigned v,
                                               input longint unsigned mx);
      return (v < mx) ? v + 1 : v;
   endfunction

   // One clock edge of the monitor described by its rules: count while running, track the
   // run of non-stalled zero fetches, finish at the limit or (optionally) at the cycle cap.
   function automatic mdl_t mdl_step(input mdl_t cur, input int unsigned limit,
                                     input longint unsigned mx, input longint unsigned max_cyc,
                                     input bit st, input bit cl, input bit sl, input bit br,
                                     input bit fl, input logic [31:0] ins, input bit rt);
      mdl_t nx;
      nx = cur;
      if (cl) begin
         nx = '{default: 0};
         return nx;
      end
      if (cur.fin) return nx;
      if (!st) begin
         nx.run  = 1'b0;
         nx.zrun = 0;
         return nx;
      end
      if (!cur.run) begin
         nx.run = 1'b1;
         return nx;
      end
      nx.cyc = sat_inc(cur.cyc, mx);
      if (sl && !br) nx.stl = sat_inc(cur.stl, mx);
      if (fl) nx.fls = sat_inc(cur.fls, mx);
      if (rt) nx.ret = sat_inc(cur.ret, mx);
      if (ins != 32'd0) nx.zrun = 0;
      else if (fl && (cur.zrun != 0)) nx.zrun = 0;
      else if (!sl) nx.zrun = cur.zrun + 1;
      if (nx.zrun == limit) begin
         nx.fin = 1'b1;
      end
`ifdef PERF_MON_WATCHDOG_EN
      else if ((nx.cyc == max_cyc) && (nx.cyc != cur.cyc)) begin
         nx.fin  = 1'b1;
         nx.tout = 1'b1;
      end
`else
      if (max_cyc == 0) nx.tout = 1'b0;
`endif
      return nx;
   endfunction

   task automatic reset_models();
      for (int i = 0; i < 3; i++) m[i] = '{default: 0};
   endtask

   task automatic check_all();
      check_eq("a.cycle", cyc_a, m[0].cyc);
      check_eq("a.stall", stl_a, m[0].stl);
      check_eq("a.flush", fls_a, m[0].fls);
      check_eq("a.retire", ret_a, m[0].ret);
      check_eq("a.done", done_a, m[0].fin);
      check_eq("a.timeout", tout_a, m[0].tout);
      check_eq("b.cycle", cyc_b, m[1].cyc);
      check_eq("b.stall", stl_b, m[1].stl);
      check_eq("b.flush", fls_b, m[1].fls);
      check_eq("b.retire", ret_b, m[1].ret);
      check_eq("b.done", done_b, m[1].fin);
      check_eq("b.timeout", tout_b, m[1].tout);
      check_eq("c.cycle", cyc_c, m[2].cyc);
      check_eq("c.stall", stl_c, m[2].stl);
      check_eq("c.flush", fls_c, m[2].fls);
      check_eq("c.retire", ret_c, m[2].ret);
      check_eq("c.done", done_c, m[2].fin);
      check_eq("c.timeout", tout_c, m[2].tout);
   endtask

   // Inputs are already stable; take one edge, advance the models, then compare.
   task automatic step();
      @(posedge clk);
      m[0] = mdl_step(m[0], 8, 64'hFFFF_FFFF, 1024, start, clear, stall, branch, flush, instr,
                      retire);
      m[1] = mdl_step(m[1], 1, 15, 1024, start, clear, stall, branch, flush, instr, retire);
      m[2] = mdl_step(m[2], 8, 255, 20, start, clear, stall, branch, flush, instr, retire);
      #1;
      check_all();
   endtask

   task automatic drive(input bit st, input bit sl, input bit br, input bit fl,
                        input logic [31:0] ins, input bit rt);
      start  = st;
      clear  = 1'b0;
      stall  = sl;
      branch = br;
      flush  = fl;
      instr  = ins;
      retire = rt;
      step();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   function automatic logic [31:0] nz();
      return $urandom() | 32'h1;
   endfunction

   longint unsigned sv_cyc, sv_stl, sv_fls, sv_ret;
   bit              zero_seq [11];

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      rst    = 1'b1;
      start  = 1'b0;
      clear  = 1'b0;
      stall  = 1'b0;
      branch = 1'b0;
      flush  = 1'b0;
      instr  = 32'd0;
      retire = 1'b0;
      reset_models();
      #3;
      check_all();
      check_eq("reset.cycle", cyc_a, 0);
      check_eq("reset.done", done_a, 0);
      @(negedge clk);
      rst = 1'b0;

      // Start edge counts nothing, then 10 running edges with real instructions.
      drive(1, 0, 0, 0, nz(), 0);
      check_eq("s1.start_edge_cycle", cyc_a, 0);
      for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, nz(), 0);
      check_eq("s1.cycle", cyc_a, 10);
      check_eq("s1.stall", stl_a, 0);
      check_eq("s1.flush", fls_a, 0);
      check_eq("s1.retire", ret_a, 0);
      check_eq("s1.done", done_a, 0);

      // Data-hazard stalls count, branch stalls do not; stall+flush bumps both.
      for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, nz(), 1);
      for (int i = 0; i < 2; i++) drive(1, 1, 1, 0, nz(), 0);
      drive(1, 1, 0, 1, nz(), 0);
      check_eq("s2.stall", stl_a, 4);
      check_eq("s2.flush", fls_a, 1);
      check_eq("s2.retire", ret_a, 3);

      // Short zero run broken by a fetch, then a full run of 8 zeros.
      for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 32'd0, 0);
      drive(1, 0, 0, 0, nz(), 0);
      for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 32'd0, 1);
      check_eq("s3.done_before_limit", done_a, 0);
      drive(1, 0, 0, 0, 32'd0, 1);
      check_eq("s3.done_at_limit", done_a, 1);
      check_eq("s3.cycle", cyc_a, 30);
      sv_cyc = cyc_a;
      sv_stl = stl_a;
      sv_fls = fls_a;
      sv_ret = ret_a;
      for (int i = 0; i < 5; i++) drive(1, 1, 0, 1, $urandom(), 1);
      check_eq("s3.frozen_cycle", cyc_a, sv_cyc);
      check_eq("s3.frozen_stall", stl_a, sv_stl);
      check_eq("s3.frozen_flush", fls_a, sv_fls);
      check_eq("s3.frozen_retire", ret_a, sv_ret);
      check_eq("s3.frozen_done", done_a, 1);

      // Zero stream with three stalled zero edges mixed in.
      pulse_clear();
      check_eq("s4.cleared_done", done_a, 0);
      drive(1, 0, 0, 0, nz(), 0);
      zero_seq = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
      for (int i = 0; i < 11; i++) begin
         drive(1, zero_seq[i], 0, 0, 32'd0, 0);
         if (i == 9) check_eq("s4.done_before_limit", done_a, 0);
      end
      check_eq("s4.done", done_a, 1);
      check_eq("s4.stall", stl_a, 3);
      check_eq("s4.cycle", cyc_a, 11);

      // Pause holds counters; clear wipes them.
      pulse_clear();
      drive(1, 0, 0, 0, nz(), 0);
      for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, nz(), 1);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 1, nz(), 1);
      check_eq("s5.paused_cycle", cyc_a, 5);
      check_eq("s5.paused_retire", ret_a, 5);
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, nz(), 0);
      check_eq("s5.resumed_cycle", cyc_a, 7);
      pulse_clear();
      check_eq("s5.clear_cycle", cyc_a, 0);
      check_eq("s5.clear_retire", ret_a, 0);
      check_eq("s5.clear_done", done_a, 0);

      // Endless instructions: watchdog (instance c) and saturation (instance b).
      drive(1, 0, 0, 0, nz(), 0);
      for (int i = 0; i < 40; i++) drive(1, 0, 0, 0, nz(), 1);
      check_eq("s6.b_cycle_sat", cyc_b, 15);
      check_eq("s6.b_retire_sat", ret_b, 15);
`ifdef PERF_MON_WATCHDOG_EN
      check_eq("s6.c_cycle", cyc_c, 20);
      check_eq("s6.c_done", done_c, 1);
      check_eq("s6.c_timeout", tout_c, 1);
`else
      check_eq("s6.c_cycle", cyc_c, 40);
      check_eq("s6.c_done", done_c, 0);
      check_eq("s6.c_timeout", tout_c, 0);
`endif

      // Asynchronous reset between edges.
      pulse_clear();
      drive(1, 0, 0, 0, nz(), 0);
      for (int i = 0; i < 5; i++) drive(1, 1, 0, 1, nz(), 1);
      #2;
      rst = 1'b1;
      #1;
      reset_models();
      check_all();
      check_eq("s7.async_cycle", cyc_a, 0);
      check_eq("s7.async_stall", stl_a, 0);
      #1;
      rst = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         start  = ($urandom_range(0, 99) < 95);
         clear  = ($urandom_range(0, 99) < 2);
         stall  = ($urandom_range(0, 99) < 20);
         branch = ($urandom_range(0, 99) < 30);
         flush  = ($urandom_range(0, 99) < 10);
         instr  = ($urandom_range(0, 99) < 45) ? 32'd0 : $urandom();
         retire = ($urandom_range(0, 99) < 50);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_perf_monitor.md
# pipeline_perf_monitor

Event counter and end-of-program detector attached to the pipelined CPU, directly upstream of the simulation testbench. It samples the CPU's start, hazard-unit stall/flush, fetch and write-back signals every cycle and accumulates cycle, stall, flush and retired-instruction counts. It asserts `done_o` once the fetch stream has run dry, so the bench stops on program completion instead of a fixed cycle count.

## Interface
- `CNT_W`, 32: width of every event counter.
- `IDLE_LIMIT`, 8: consecutive non-stalled all-zero fetches that declare the program finished; legal range 1..255.
- `MAX_CYCLES`, 1024: watchdog limit; used only with `PERF_MON_WATCHDOG_EN`.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: CPU start; monitoring is active only while it is high.
- `clear_i` in 1: synchronous clear of the counters and state.
- `stall_i` in 1: hazard-detection stall (IF/ID hold).
- `branch_i` in 1: branch decoded in ID; a stall with this high is not a data-hazard stall.
- `flush_i` in 1: IF/ID flush from a taken branch.
- `instr_i` in 32: instruction currently in the IF stage.
- `retire_i` in 1: a valid non-bubble instruction is in WB this cycle.
- `cycle_o`, `stall_o`, `flush_o`, `retire_o` out CNT_W each: event counts.
- `done_o` out 1: program finished; counters frozen.
- `timeout_o` out 1: finished because of the watchdog.

## Operation
- States: IDLE, RUN, DRAIN, DONE. After reset the block is in IDLE, all counters are 0, and `done_o`=`timeout_o`=0.
- IDLE to RUN on the first edge with `start_i`=1. That edge counts nothing.
- In RUN and DRAIN, the following happens on each edge:
  - `cycle_o` increments by 1.
  - `stall_o` increments when `stall_i`=1 and `branch_i`=0.
  - `flush_o` increments when `flush_i`=1.
  - `retire_o` increments when `retire_i`=1.
- RUN to DRAIN on an edge with `instr_i`=0 and `stall_i`=0. The drain count is set to 1 on that edge.
- In DRAIN, each edge with `instr_i`=0 and `stall_i`=0 increments the drain count.
  - A stalled edge holds the drain count.
  - An edge with `instr_i`≠0 or `flush_i`=1 returns the block to RUN and zeroes the drain count.
- When the drain count reaches `IDLE_LIMIT`, the block enters DONE. Events on that terminating edge are still counted.
- In DONE, counters are frozen and `done_o`=1. DONE is left only by `rst_i` or `clear_i`.
- `start_i`=0 in RUN or DRAIN returns the block to IDLE. Counters and drain count hold (pause). The next start resumes counting.
- `clear_i` takes priority over all events. It zeroes counters and drain count, deasserts `done_o`/`timeout_o`, and puts the block in IDLE.
- All counters saturate at all-ones and never wrap.

## Timing
- Latency: an event sampled at edge N is visible on the outputs after edge N. Outputs are registered.
- `done_o` rises in the cycle after the terminating edge.
- Asserting `rst_i` mid-run clears everything immediately, with no clock needed.
- Simultaneous stall+flush on one edge increments both counters.
- `IDLE_LIMIT`=1 goes RUN to DONE on a single zero fetch, with no DRAIN cycle.

## Configuration
- Macro `PERF_MON_WATCHDOG_EN`.
  - Defined: in RUN or DRAIN, the edge on which `cycle_o` becomes `MAX_CYCLES` forces DONE with `timeout_o`=1. If the drain limit is also reached on that edge, `timeout_o`=0.
  - Undefined: `timeout_o` is tied to 0 and `MAX_CYCLES` is ignored.

## Structure
- Package `perf_mon_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the default `CNT_W`;
  - the drain-count width constant (8 bits).
- Sub-module `perf_sat_counter`: a saturating counter with enable and synchronous clear, parameterised by width. It is instantiated four times.

## Test plan
- Reset, `start_i`=1, nonzero `instr_i` for 10 edges → `cycle_o`=10; `stall_o`=`flush_o`=`retire_o`=0; `done_o`=0.
- 3 edges with `stall_i`=1, `branch_i`=0, then 2 with `stall_i`=1, `branch_i`=1, then 1 with `stall_i`=1 and `flush_i`=1 → `stall_o`=4, `flush_o`=1.
- `instr_i`=0 for 5 edges, one nonzero, then 8 zeros → `done_o` rises after the 8th zero. A further 5 edges leave all counters unchanged.
- Zero stream interleaved with 3 stalled edges, `IDLE_LIMIT`=8 → `done_o` rises after 8 non-stalled zero edges, and `stall_o` includes the 3.
- Drop `start_i` for 4 edges mid-run → `cycle_o` holds. Then pulse `clear_i` → all counters 0, state IDLE, `done_o`=0.
- With `PERF_MON_WATCHDOG_EN` and `MAX_CYCLES`=20, nonzero instructions forever → `done_o`=`timeout_o`=1 with `cycle_o`=20. Repeat with `CNT_W`=4 and no macro → `cycle_o` saturates at 15.
